// File: rtl/axi_pkg.sv
// AXI4 field widths, burst/response codes and channel FSM states shared by
// the memory slave and the DMA controller.
package axi_pkg;

  localparam int LEN_WD   = 8;
  localparam int SIZE_WD  = 3;
  localparam int BURST_WD = 2;
  localparam int RESP_WD  = 2;

  localparam logic [BURST_WD-1:0] BURST_FIXED = 2'd0;
  localparam logic [BURST_WD-1:0] BURST_INCR  = 2'd1;
  localparam logic [BURST_WD-1:0] BURST_WRAP  = 2'd2;

  localparam logic [RESP_WD-1:0] RESP_OKAY   = 2'd0;
  localparam logic [RESP_WD-1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_t;

  function automatic logic wrap_len_ok(input logic [LEN_WD-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational AXI beat-address stepper plus whole-burst legality check;
// err treats addr as the burst start address.
module axi_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WD   = 32,
  parameter int STRB_WD   = 4,
  parameter int MEM_BYTES = 1024
) (
  input  logic [ADDR_WD-1:0]  addr,
  input  logic [LEN_WD-1:0]   len,
  input  logic [SIZE_WD-1:0]  size,
  input  logic [BURST_WD-1:0] burst,
  output logic [ADDR_WD-1:0]  next_addr,
  output logic                err
);

  // Error arithmetic runs wider than the bus so the highest beat cannot wrap
  localparam int EW = ADDR_WD + 16;

  logic [ADDR_WD-1:0] sb_n_s, aligned_n_s, incr_n_s, wrap_mask_n_s;
  logic [EW-1:0]      a_w_s, sb_w_s, aligned_w_s, wrap_bytes_w_s, incr_top_w_s, top_w_s;
  logic               size_err_s, wrap_err_s, oob_s;

  // Next beat address and highest beat address of the burst
  always_comb begin
    sb_n_s         = ADDR_WD'(1) << size;
    aligned_n_s    = addr & ~(sb_n_s - ADDR_WD'(1));
    incr_n_s       = aligned_n_s + sb_n_s;
    wrap_mask_n_s  = ((ADDR_WD'(len) + ADDR_WD'(1)) << size) - ADDR_WD'(1);
    a_w_s          = EW'(addr);
    sb_w_s         = EW'(1) << size;
    aligned_w_s    = a_w_s & ~(sb_w_s - EW'(1));
    wrap_bytes_w_s = (EW'(len) + EW'(1)) << size;
    incr_top_w_s   = aligned_w_s + (EW'(len) << size);
    size_err_s     = (sb_w_s > EW'(STRB_WD));
    wrap_err_s     = 1'b0;
    case (burst)
      BURST_FIXED: begin
        next_addr = addr;
        top_w_s   = a_w_s;
      end
      BURST_WRAP: begin
        next_addr  = (addr & ~wrap_mask_n_s) | (incr_n_s & wrap_mask_n_s);
        top_w_s    = (a_w_s & ~(wrap_bytes_w_s - EW'(1))) + wrap_bytes_w_s - sb_w_s;
        wrap_err_s = !wrap_len_ok(len) || (addr != aligned_n_s);
      end
      default: begin
        next_addr = incr_n_s;
        top_w_s   = (a_w_s > incr_top_w_s) ? a_w_s : incr_top_w_s;
      end
    endcase
    oob_s = (top_w_s >= EW'(MEM_BYTES));
    err   = size_err_s | wrap_err_s | oob_s;
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave backed by an internal byte-writable RAM; read and write channels
// run as independent FSMs sharing only the RAM.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int ADDR_WD   = 32,
  parameter int DATA_WD   = 32,
  parameter int MEM_DEPTH = 256,
  parameter int STRB_WD   = DATA_WD / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  input  logic [ADDR_WD-1:0]  S_AXI_ARADDR,
  input  logic [LEN_WD-1:0]   S_AXI_ARLEN,
  input  logic [SIZE_WD-1:0]  S_AXI_ARSIZE,
  input  logic [BURST_WD-1:0] S_AXI_ARBURST,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY,
  output logic [DATA_WD-1:0]  S_AXI_RDATA,
  output logic [RESP_WD-1:0]  S_AXI_RRESP,
  output logic                S_AXI_RLAST,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [ADDR_WD-1:0]  S_AXI_AWADDR,
  input  logic [LEN_WD-1:0]   S_AXI_AWLEN,
  input  logic [SIZE_WD-1:0]  S_AXI_AWSIZE,
  input  logic [BURST_WD-1:0] S_AXI_AWBURST,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  input  logic [DATA_WD-1:0]  S_AXI_WDATA,
  input  logic [STRB_WD-1:0]  S_AXI_WSTRB,
  input  logic                S_AXI_WLAST,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  output logic [RESP_WD-1:0]  S_AXI_BRESP
);

  localparam int LSB       = $clog2(STRB_WD);
  localparam int DEPTH_WD  = $clog2(MEM_DEPTH);
  localparam int MEM_BYTES = MEM_DEPTH * STRB_WD;

  logic [DATA_WD-1:0] mem_r [MEM_DEPTH];

  rd_state_t           rd_state_r;
  logic [ADDR_WD-1:0]  rd_addr_r, rd_gen_addr_s, rd_next_s, rd_beat_addr_s;
  logic [LEN_WD-1:0]   rd_len_r, rd_cnt_r, rd_gen_len_s;
  logic [SIZE_WD-1:0]  rd_size_r, rd_gen_size_s;
  logic [BURST_WD-1:0] rd_burst_r, rd_gen_burst_s;
  logic                rd_err_r, rd_err_s;
  logic [DATA_WD-1:0]  rd_word_s;

  wr_state_t           wr_state_r;
  logic [ADDR_WD-1:0]  wr_addr_r, wr_gen_addr_s, wr_next_s;
  logic [LEN_WD-1:0]   wr_len_r, wr_cnt_r, wr_gen_len_s;
  logic [SIZE_WD-1:0]  wr_size_r, wr_gen_size_s;
  logic [BURST_WD-1:0] wr_burst_r, wr_gen_burst_s;
  logic                wr_err_r, wr_err_s, wr_wlast_err_r, wr_last_beat_s, wr_mismatch_s, wr_en_s;
  logic [DEPTH_WD-1:0] wr_idx_s;

  // In idle the generators look at the incoming request, otherwise at the live burst
  assign rd_gen_addr_s  = (rd_state_r == R_IDLE) ? S_AXI_ARADDR  : rd_addr_r;
  assign rd_gen_len_s   = (rd_state_r == R_IDLE) ? S_AXI_ARLEN   : rd_len_r;
  assign rd_gen_size_s  = (rd_state_r == R_IDLE) ? S_AXI_ARSIZE  : rd_size_r;
  assign rd_gen_burst_s = (rd_state_r == R_IDLE) ? S_AXI_ARBURST : rd_burst_r;
  assign rd_beat_addr_s = (rd_state_r == R_IDLE) ? S_AXI_ARADDR  : rd_next_s;
  assign rd_word_s      = mem_r[DEPTH_WD'(rd_beat_addr_s >> LSB)];

  assign wr_gen_addr_s  = (wr_state_r == W_IDLE) ? S_AXI_AWADDR  : wr_addr_r;
  assign wr_gen_len_s   = (wr_state_r == W_IDLE) ? S_AXI_AWLEN   : wr_len_r;
  assign wr_gen_size_s  = (wr_state_r == W_IDLE) ? S_AXI_AWSIZE  : wr_size_r;
  assign wr_gen_burst_s = (wr_state_r == W_IDLE) ? S_AXI_AWBURST : wr_burst_r;
  assign wr_last_beat_s = (wr_cnt_r == wr_len_r);
  assign wr_mismatch_s  = (S_AXI_WLAST != wr_last_beat_s);
  assign wr_idx_s       = DEPTH_WD'(wr_addr_r >> LSB);
  assign wr_en_s        = (wr_state_r == W_DATA) && S_AXI_WVALID && S_AXI_WREADY && !wr_err_r && !rst;

  axi_addr_gen #(.ADDR_WD(ADDR_WD), .STRB_WD(STRB_WD), .MEM_BYTES(MEM_BYTES)) u_rd_gen (
    .addr(rd_gen_addr_s), .len(rd_gen_len_s), .size(rd_gen_size_s), .burst(rd_gen_burst_s),
    .next_addr(rd_next_s), .err(rd_err_s)
  );

  axi_addr_gen #(.ADDR_WD(ADDR_WD), .STRB_WD(STRB_WD), .MEM_BYTES(MEM_BYTES)) u_wr_gen (
    .addr(wr_gen_addr_s), .len(wr_gen_len_s), .size(wr_gen_size_s), .burst(wr_gen_burst_s),
    .next_addr(wr_next_s), .err(wr_err_s)
  );

  // RAM write port with per-lane strobes; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int b = 0; b < STRB_WD; b++) begin
        if (S_AXI_WSTRB[b]) mem_r[wr_idx_s][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Read channel FSM; RDATA is fetched one beat ahead so R outputs are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_r    <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RDATA   <= {DATA_WD{1'b0}};
      S_AXI_RRESP   <= RESP_OKAY;
      rd_addr_r     <= {ADDR_WD{1'b0}};
      rd_len_r      <= 8'd0;
      rd_cnt_r      <= 8'd0;
      rd_size_r     <= 3'd0;
      rd_burst_r    <= BURST_FIXED;
      rd_err_r      <= 1'b0;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (S_AXI_ARREADY && S_AXI_ARVALID) begin
            rd_addr_r     <= S_AXI_ARADDR;
            rd_len_r      <= S_AXI_ARLEN;
            rd_size_r     <= S_AXI_ARSIZE;
            rd_burst_r    <= S_AXI_ARBURST;
            rd_cnt_r      <= 8'd0;
            rd_err_r      <= rd_err_s;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
            S_AXI_RDATA   <= rd_err_s ? {DATA_WD{1'b0}} : rd_word_s;
            S_AXI_RRESP   <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
            rd_state_r    <= R_DATA;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RVALID && S_AXI_RREADY) begin
            if (S_AXI_RLAST) begin
              S_AXI_RVALID  <= 1'b0;
              S_AXI_RLAST   <= 1'b0;
              S_AXI_ARREADY <= 1'b1;
              rd_state_r    <= R_IDLE;
            end else begin
              rd_cnt_r    <= rd_cnt_r + 8'd1;
              rd_addr_r   <= rd_next_s;
              S_AXI_RLAST <= ((rd_cnt_r + 8'd1) == rd_len_r);
              S_AXI_RDATA <= rd_err_r ? {DATA_WD{1'b0}} : rd_word_s;
            end
          end
        end
        default: begin
          rd_state_r    <= R_IDLE;
          S_AXI_ARREADY <= 1'b0;
          S_AXI_RVALID  <= 1'b0;
          S_AXI_RLAST   <= 1'b0;
        end
      endcase
    end
  end

  // Write channel FSM; WLAST disagreements are remembered and reported in BRESP
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_r     <= W_IDLE;
      S_AXI_AWREADY  <= 1'b0;
      S_AXI_WREADY   <= 1'b0;
      S_AXI_BVALID   <= 1'b0;
      S_AXI_BRESP    <= RESP_OKAY;
      wr_addr_r      <= {ADDR_WD{1'b0}};
      wr_len_r       <= 8'd0;
      wr_cnt_r       <= 8'd0;
      wr_size_r      <= 3'd0;
      wr_burst_r     <= BURST_FIXED;
      wr_err_r       <= 1'b0;
      wr_wlast_err_r <= 1'b0;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          if (S_AXI_AWREADY && S_AXI_AWVALID) begin
            wr_addr_r      <= S_AXI_AWADDR;
            wr_len_r       <= S_AXI_AWLEN;
            wr_size_r      <= S_AXI_AWSIZE;
            wr_burst_r     <= S_AXI_AWBURST;
            wr_cnt_r       <= 8'd0;
            wr_err_r       <= wr_err_s;
            wr_wlast_err_r <= 1'b0;
            S_AXI_AWREADY  <= 1'b0;
            S_AXI_WREADY   <= 1'b1;
            wr_state_r     <= W_DATA;
          end else begin
            S_AXI_AWREADY <= 1'b1;
          end
        end
        W_DATA: begin
          if (S_AXI_WVALID && S_AXI_WREADY) begin
            if (wr_last_beat_s) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP  <= (wr_err_r || wr_wlast_err_r || wr_mismatch_s) ? RESP_SLVERR : RESP_OKAY;
              wr_state_r   <= W_RESP;
            end else begin
              wr_cnt_r       <= wr_cnt_r + 8'd1;
              wr_addr_r      <= wr_next_s;
              wr_wlast_err_r <= wr_wlast_err_r | wr_mismatch_s;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            wr_state_r    <= W_IDLE;
          end
        end
        default: begin
          wr_state_r    <= W_IDLE;
          S_AXI_AWREADY <= 1'b0;
          S_AXI_WREADY  <= 1'b0;
          S_AXI_BVALID  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: bursts, wrap, narrow strobes, back-pressure,
// error responses and mid-burst reset, checked against hand-computed values.
module tb_axi_slave_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd_q [16];
  logic [3:0]  ws_q [16];
  logic [31:0] rd_q [16];
  logic [1:0]  rr_q [16];
  logic        rl_q [16];
  logic [1:0]  bresp_got;

  always #5 clk = ~clk;

  axi_slave_mem dut (
    .clk(clk), .rst(rst),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_ARADDR(araddr),
    .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RDATA(rdata),
    .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready), .S_AXI_AWADDR(awaddr),
    .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize), .S_AXI_AWBURST(awburst),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_WDATA(wdata),
    .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig_sel(input int which);
    case (which)
      0: return awready;
      1: return wready;
      2: return bvalid;
      3: return arready;
      4: return rvalid;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_hi(input int which, input string tag);
    int n = 0;
    while (sig_sel(which) !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, sig_sel(which)}, 32'd1);
  endtask

  // wl_mode: 0 WLAST on last beat, 1 WLAST never, 2 WLAST on every beat
  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                          input logic [1:0] bt, input int wl_mode);
    awaddr = a; awlen = len; awsize = sz; awburst = bt; awvalid = 1'b1;
    wait_hi(0, "aw");
    tick();
    awvalid = 1'b0;
    chk("wready_lat", {31'd0, wready}, 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wd_q[i]; wstrb = ws_q[i];
      wlast = (wl_mode == 0) ? (i == int'(len)) : (wl_mode == 2);
      wvalid = 1'b1;
      wait_hi(1, "w");
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_lat", {31'd0, bvalid}, 32'd1);
    bready = 1'b1;
    bresp_got = bresp;
    tick();
    bready = 1'b0;
    chk("awready_ret", {31'd0, awready}, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bt, input int hold_at);
    logic [31:0] snap_d;
    logic        snap_l;
    araddr = a; arlen = len; arsize = sz; arburst = bt; arvalid = 1'b1;
    wait_hi(3, "ar");
    tick();
    arvalid = 1'b0;
    chk("rvalid_lat", {31'd0, rvalid}, 32'd1);
    rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == hold_at) begin
        rready = 1'b0;
        snap_d = rdata; snap_l = rlast;
        repeat (2) begin
          tick();
          chk("hold_rvalid", {31'd0, rvalid}, 32'd1);
          chk("hold_rdata", rdata, snap_d);
          chk("hold_rlast", {31'd0, rlast}, {31'd0, snap_l});
        end
        rready = 1'b1;
      end
      wait_hi(4, "r");
      rd_q[i] = rdata; rr_q[i] = rresp; rl_q[i] = rlast;
      tick();
    end
    rready = 1'b0;
    chk("arready_ret", {31'd0, arready}, 32'd1);
  endtask

  task automatic chk_beats(input string tag, input int len, input logic [31:0] exp_d [16],
                           input logic [1:0] exp_r);
    for (int i = 0; i <= len; i++) begin
      chk($sformatf("%s_rdata%0d", tag, i), rd_q[i], exp_d[i]);
      chk($sformatf("%s_rresp%0d", tag, i), 32'(rr_q[i]), 32'(exp_r));
      chk($sformatf("%s_rlast%0d", tag, i), 32'(rl_q[i]), 32'(i == len));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_d [16];
    rst = 1'b1;
    arvalid = 1'b0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1; rready = 1'b0;
    awvalid = 1'b0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1;
    wvalid = 1'b0; wdata = 32'd0; wstrb = 4'h0; wlast = 1'b0; bready = 1'b0;
    repeat (3) tick();
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready",  {31'd0, wready},  32'd0);
    chk("rst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("rst_rlast",   {31'd0, rlast},   32'd0);
    chk("rst_rdata",   rdata,            32'd0);
    chk("rst_rresp",   32'(rresp),       32'd0);
    chk("rst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("rst_bresp",   32'(bresp),       32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_arready", {31'd0, arready}, 32'd1);
    chk("post_rst_awready", {31'd0, awready}, 32'd1);

    // INCR write then read back 0x10..0x1C
    wd_q[0] = 32'h11; wd_q[1] = 32'h22; wd_q[2] = 32'h33; wd_q[3] = 32'h44;
    for (int i = 0; i < 16; i++) ws_q[i] = 4'hF;
    do_write(32'h10, 8'd3, 3'd2, 2'd1, 0);
    chk("incr_bresp", 32'(bresp_got), 32'd0);
    do_read(32'h10, 8'd3, 3'd2, 2'd1, -1);
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    chk_beats("incr", 3, exp_d, 2'd0);

    // WRAP from 0x18 visits 0x18,0x1C,0x10,0x14
    do_read(32'h18, 8'd3, 3'd2, 2'd2, -1);
    exp_d[0] = 32'h33; exp_d[1] = 32'h44; exp_d[2] = 32'h11; exp_d[3] = 32'h22;
    chk_beats("wrap", 3, exp_d, 2'd0);

    // Narrow byte writes into a cleared word at 0x20
    wd_q[0] = 32'h0;
    do_write(32'h20, 8'd0, 3'd2, 2'd1, 0);
    wd_q[0] = 32'h0000_AA00; ws_q[0] = 4'h2;
    wd_q[1] = 32'h00BB_0000; ws_q[1] = 4'h4;
    do_write(32'h21, 8'd1, 3'd0, 2'd1, 0);
    chk("narrow_bresp", 32'(bresp_got), 32'd0);
    do_read(32'h20, 8'd0, 3'd2, 2'd1, -1);
    exp_d[0] = 32'h00BB_AA00;
    chk_beats("narrow", 0, exp_d, 2'd0);
    for (int i = 0; i < 16; i++) ws_q[i] = 4'hF;

    // RREADY back-pressure on beat 1
    do_read(32'h10, 8'd3, 3'd2, 2'd1, 1);
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    chk_beats("bp", 3, exp_d, 2'd0);

    // Missing WLAST -> SLVERR but data lands; early WLAST -> SLVERR
    wd_q[0] = 32'hA0; wd_q[1] = 32'hA1; wd_q[2] = 32'hA2; wd_q[3] = 32'hA3;
    do_write(32'h40, 8'd3, 3'd2, 2'd1, 1);
    chk("nolast_bresp", 32'(bresp_got), 32'd2);
    do_read(32'h40, 8'd3, 3'd2, 2'd1, -1);
    exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3;
    chk_beats("nolast", 3, exp_d, 2'd0);
    do_write(32'h50, 8'd1, 3'd2, 2'd1, 2);
    chk("early_bresp", 32'(bresp_got), 32'd2);

    // Out-of-range, boundary-crossing, bad wrap length and oversize beats
    for (int i = 0; i < 16; i++) exp_d[i] = 32'd0;
    do_read(32'h400, 8'd1, 3'd2, 2'd1, -1);
    chk_beats("oob", 1, exp_d, 2'd2);
    do_read(32'h3FC, 8'd1, 3'd2, 2'd1, -1);
    chk_beats("cross", 1, exp_d, 2'd2);
    do_read(32'h10, 8'd2, 3'd2, 2'd2, -1);
    chk_beats("wraplen", 2, exp_d, 2'd2);
    wd_q[0] = 32'h1234_5678;
    do_write(32'h60, 8'd0, 3'd2, 2'd1, 0);
    chk("pre_size_bresp", 32'(bresp_got), 32'd0);
    wd_q[0] = 32'hDEAD_BEEF;
    do_write(32'h60, 8'd0, 3'd3, 2'd1, 0);
    chk("size_bresp", 32'(bresp_got), 32'd2);
    do_read(32'h60, 8'd0, 3'd2, 2'd1, -1);
    exp_d[0] = 32'h1234_5678;
    chk_beats("size_keep", 0, exp_d, 2'd0);

    // Concurrent 16-beat bursts, then reset mid-burst
    araddr = 32'h200; arlen = 8'd15; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b1;
    awaddr = 32'h100; awlen = 8'd15; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b1;
    chk("conc_arready", {31'd0, arready}, 32'd1);
    chk("conc_awready", {31'd0, awready}, 32'd1);
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    chk("conc_rvalid", {31'd0, rvalid}, 32'd1);
    chk("conc_wready", {31'd0, wready}, 32'd1);
    rready = 1'b1; wvalid = 1'b1; wdata = 32'h5555_0000; wstrb = 4'hF; wlast = 1'b0;
    repeat (3) tick();
    chk("conc_mid_rvalid", {31'd0, rvalid}, 32'd1);
    chk("conc_mid_rlast",  {31'd0, rlast},  32'd0);
    chk("conc_mid_wready", {31'd0, wready}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mrst_rvalid",  {31'd0, rvalid},  32'd0);
    chk("mrst_rlast",   {31'd0, rlast},   32'd0);
    chk("mrst_wready",  {31'd0, wready},  32'd0);
    chk("mrst_bvalid",  {31'd0, bvalid},  32'd0);
    chk("mrst_arready", {31'd0, arready}, 32'd0);
    chk("mrst_awready", {31'd0, awready}, 32'd0);
    rst = 1'b0; rready = 1'b0; wvalid = 1'b0;
    tick();
    chk("mrst_arready_up", {31'd0, arready}, 32'd1);
    chk("mrst_awready_up", {31'd0, awready}, 32'd1);
    do_read(32'h10, 8'd0, 3'd2, 2'd1, -1);
    exp_d[0] = 32'h11;
    chk_beats("after_rst", 0, exp_d, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

AXI4 memory-mapped slave with internal RAM; the responder end of the DMA controller's AXI master ports. Accepts read and write bursts (FIXED/INCR/WRAP, narrow sizes, byte strobes) on independent read and write paths. Serves as the DMA's source and destination memory in system simulation and as an on-chip scratch RAM.

## Interface
- ADDR_WD, 32, address width
- DATA_WD, 32, data width (32/64/128); STRB_WD = DATA_WD/8
- MEM_DEPTH, 256, RAM depth in DATA_WD words; byte capacity = MEM_DEPTH*STRB_WD

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- S_AXI_ARVALID/ARREADY  in/out  1  read-address handshake
- S_AXI_ARADDR  in  ADDR_WD  byte start address
- S_AXI_ARLEN  in  8  beats-1
- S_AXI_ARSIZE  in  3  log2 bytes per beat
- S_AXI_ARBURST  in  2  0 FIXED, 1 INCR, 2 WRAP
- S_AXI_RVALID/RREADY  out/in  1  read-data handshake
- S_AXI_RDATA  out  DATA_WD  full word at beat address
- S_AXI_RRESP  out  2  0 OKAY, 2 SLVERR
- S_AXI_RLAST  out  1  final beat
- S_AXI_AWVALID/AWREADY, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST: as AR equivalents
- S_AXI_WVALID/WREADY  in/out  1  write-data handshake
- S_AXI_WDATA  in  DATA_WD; S_AXI_WSTRB  in  STRB_WD; S_AXI_WLAST  in  1
- S_AXI_BVALID/BREADY  out/in  1; S_AXI_BRESP  out  2

## Operation
- Read FSM R_IDLE -> R_DATA -> R_IDLE. ARREADY=1 only in R_IDLE. AR handshake latches addr/len/size/burst, beat counter=0, error flag.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. AWREADY=1 only in W_IDLE; WREADY=1 only in W_DATA; BVALID=1 only in W_RESP.
- Word index = (beat_addr >> log2(STRB_WD)) mod MEM_DEPTH.
- Next address: FIXED unchanged; INCR = (addr aligned down to 2^size) + 2^size; WRAP as INCR but wraps within boundary of (len+1)*2^size bytes aligned.
- Error (SLVERR for whole burst): 2^size > STRB_WD; WRAP with len not in {1,3,7,15} or unaligned start; any beat address >= MEM_DEPTH*STRB_WD. Errored write beats drop (RAM unchanged); errored read beats return RDATA=0, RRESP=2 on every beat, RLAST still correct.
- Write beats: per byte lane, write if WSTRB bit set. Master lane selection honored as given; no lane masking by size.
- Beat counter governs burst end. On counted last beat, WLAST must be 1; mismatch (early or missing WLAST) -> BRESP=SLVERR, data already written stays. Early WLAST does not end burst.
- Read and write paths fully concurrent; RAM has one read port and one write port.

## Timing
- Reset values: ARREADY=0, AWREADY=0, WREADY=0, RVALID=0, RLAST=0, RDATA=0, RRESP=0, BVALID=0, BRESP=0. ARREADY/AWREADY rise first cycle after rst deasserts. RAM contents not reset.
- AR handshake at edge N -> first RVALID at N+1. Each RVALID&&RREADY advances; next beat valid the following cycle (one beat/cycle at full RREADY). RDATA/RRESP/RLAST stable while RVALID&&!RREADY.
- After last R handshake, ARREADY=1 next cycle (min 1 idle cycle between bursts).
- AW handshake at N -> WREADY at N+1. Write lands in RAM at the W handshake edge.
- Last W handshake at M -> BVALID at M+1; held until BREADY; AWREADY returns cycle after B handshake.
- Same-word read and write in same cycle: read returns old data.
- All outputs registered; no combinational input-to-output paths.
- rst mid-burst: both FSMs to idle immediately, in-flight beats and responses discarded.

## Structure
- Package axi_pkg: burst codes (FIXED/INCR/WRAP), resp codes (OKAY/SLVERR), ARLEN/size field widths; shared with the DMA controller.
- Sub-module axi_addr_gen: combinational next-address and error check from addr/len/size/burst; instantiated once per path.
- RAM as reg array with byte-lane write enables, inside top.

## Test plan
- INCR write AWADDR=0x10, LEN=3, SIZE=2, data 0x11..0x44, WSTRB=0xF -> BRESP=0; INCR read same -> 4 beats 0x11,0x22,0x33,0x44, RLAST on beat 4 only.
- WRAP read ARADDR=0x18, LEN=3, SIZE=2 -> beat addresses 0x18,0x1C,0x10,0x14.
- Narrow write SIZE=0, AWADDR=0x21, LEN=1, WSTRB 0x2 then 0x4, bytes 0xAA,0xBB -> word 0x8 reads 0x00BBAA00 (prior zero).
- RREADY toggling 1-0-0-1 mid-burst -> RDATA/RLAST held stable, no beat lost or duplicated; WLAST missing on beat 4 of LEN=3 -> BRESP=2.
- ARADDR=MEM_DEPTH*4, LEN=1 -> 2 beats RDATA=0 RRESP=2; SIZE=3 on 32-bit bus -> SLVERR, RAM unchanged.
- Concurrent 16-beat read and write to disjoint regions, then rst asserted mid-burst -> all valids 0 next cycle, ARREADY/AWREADY=1 cycle after rst drops.
